// File: rtl/cdec_pkg.sv
// rtl/cdec_pkg.sv - shared opcode width, two-byte flag index and fetch FSM encoding
package cdec_pkg;

    localparam int OP_W         = 8;
    localparam int TWO_BYTE_BIT = 7;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2
    } fetch_state_t;

    // Opcodes with the flag bit set carry one operand byte after them.
    function automatic logic is_two_byte(input logic [OP_W-1:0] op);
        return op[TWO_BYTE_BIT];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial instruction fetch with one/two-byte decode and valid/ready output
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   rom_adrs / rom_q    program memory address (always the PC) and its combinational data
//   jump_en/jump_target redirect request; overrides everything else in every state
//   instr_valid/ready   bundle handshake towards the execute stage
//   instr_op/operand/pc fetched bundle; operand is 00 for one-byte opcodes
module fetch_unit
    import cdec_pkg::*;
#(
    parameter logic [OP_W-1:0] RESET_PC = 8'h00
) (
    input  logic            clock,
    input  logic            reset,
    output logic [OP_W-1:0] rom_adrs,
    input  logic [OP_W-1:0] rom_q,
    input  logic            jump_en,
    input  logic [OP_W-1:0] jump_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [OP_W-1:0] instr_op,
    output logic [OP_W-1:0] instr_operand,
    output logic [OP_W-1:0] instr_pc
);

    fetch_state_t    state_q;
    logic [OP_W-1:0] pc_q;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] operand_q;
    logic [OP_W-1:0] ipc_q;
    logic            valid_q;

    // valid_q is set on every transition into HOLD and cleared on every
    // transition out, so it is high exactly while the FSM sits in HOLD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            op_q      <= '0;
            operand_q <= '0;
            ipc_q     <= '0;
            valid_q   <= 1'b0;
        end else if (jump_en) begin
            // A redirect drops whatever is half-fetched or held; a bundle
            // handshaking in this same cycle has already been taken.
            state_q <= FETCH_OP;
            pc_q    <= jump_target;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    op_q  <= rom_q;
                    ipc_q <= pc_q;
                    pc_q  <= pc_q + 8'd1;
                    if (is_two_byte(rom_q)) begin
                        state_q <= FETCH_ARG;
                    end else begin
                        operand_q <= '0;
                        state_q   <= HOLD;
                        valid_q   <= 1'b1;
                    end
                end
                FETCH_ARG: begin
                    operand_q <= rom_q;
                    pc_q      <= pc_q + 8'd1;
                    state_q   <= HOLD;
                    valid_q   <= 1'b1;
                end
                HOLD: begin
                    // PC already points past the held bundle, so it is left alone.
                    if (instr_ready) begin
                        state_q <= FETCH_OP;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FETCH_OP;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rom_adrs      = pc_q;
    assign instr_valid   = valid_q;
    assign instr_op      = op_q;
    assign instr_operand = operand_q;
    assign instr_pc      = ipc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 8'h00, program counter value loaded on reset.
REQ-002 SHALL have port: clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: rom_adrs  output  8  program memory address; always equals current PC.
REQ-005 SHALL have port: rom_q  input  8  program memory data; combinational, valid in the same cycle as rom_adrs.
REQ-006 SHALL have port: jump_en  input  1  redirect request from execute stage.
REQ-007 SHALL have port: jump_target  input  8  redirect address, sampled when jump_en=1.
REQ-008 SHALL have port: instr_valid  output  1  instruction bundle available to execute stage.
REQ-009 SHALL have port: instr_ready  input  1  execute stage accepts the bundle.
REQ-010 SHALL have port: instr_op  output  8  opcode byte.
REQ-011 SHALL have port: instr_operand  output  8  second byte; 8'h00 for one-byte instructions.
REQ-012 SHALL have port: instr_pc  output  8  address of the opcode byte.

Function
REQ-013 SHALL classify an opcode with bit 7 = 1 as two-byte (opcode + operand) and bit 7 = 0 as one-byte.
REQ-014 SHALL implement FSM states FETCH_OP, FETCH_ARG, HOLD.
REQ-015 In FETCH_OP: latch rom_q into instr_op, latch PC into instr_pc, PC <= PC+1; next state FETCH_ARG if rom_q[7], else clear instr_operand and go to HOLD.
REQ-016 In FETCH_ARG: latch rom_q into instr_operand, PC <= PC+1, next state HOLD.
REQ-017 instr_valid SHALL be 1 exactly while in HOLD; output fields SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-018 In HOLD with instr_ready=1: handshake completes, next state FETCH_OP; PC unchanged.
REQ-019 Latency: one-byte instruction valid 1 cycle after entering FETCH_OP; two-byte 2 cycles.
REQ-020 jump_en=1 SHALL take priority in every state: PC <= jump_target, next state FETCH_OP, instr_valid deasserts next cycle; any partially fetched instruction is discarded.
REQ-021 jump_en=1 and instr_ready=1 in HOLD in the same cycle: bundle counts as consumed, redirect still applies.
REQ-022 PC arithmetic SHALL be modulo 256: 8'hFF + 1 = 8'h00; two-byte opcode at 8'hFF takes operand from 8'h00.
REQ-023 instr_ready SHALL be ignored outside HOLD.

Reset
REQ-024 On reset assertion, asynchronously: PC = RESET_PC, state = FETCH_OP, instr_valid = 0, instr_op = instr_operand = instr_pc = 8'h00.
REQ-025 Reset asserted mid-fetch SHALL discard all in-flight state; first fetch after deassertion reads RESET_PC.

Structure
REQ-026 State encoding, opcode width (8), and two-byte flag bit index (7) SHALL live in shared package cdec_pkg.
REQ-027 SHALL contain no sub-modules; program memory is instantiated by the parent and connected via rom_adrs/rom_q.

Verification
REQ-028 Reset, ROM = {81,07,06,22,41,C0,05,03}, instr_ready=1 -> bundles (op,operand,pc): (81,07,00),(06,00,02),(22,00,03),(41,00,04),(C0,05,05) in order.
REQ-029 instr_ready=0 for 5 cycles with bundle (81,07,00) valid -> outputs and rom_adrs stable; release -> next bundle (06,00,02).
REQ-030 jump_en=1, jump_target=05 asserted in HOLD of (C0,05,05) with instr_ready=1 -> next bundle (C0,05,05) again, no bundle from address 06.
REQ-031 jump_en=1 during FETCH_ARG of 81 at 00, target=03 -> no bundle for 81; next bundle (22,00,03).
REQ-032 RESET_PC=8'hFF, ROM[FF]=81, ROM[00]=07 -> bundle (81,07,FF), then next fetch at 01.
REQ-033 reset pulsed while in FETCH_ARG -> instr_valid=0 immediately; after release first bundle is (81,07,00).
